// File: rtl/stack_ctrl_if.sv
// Bundle of request/response, SPR strobe and data-memory signals around stack_ctrl.
// Latency: none; plain wiring bundle with no state.
// Backpressure: req_ready gates requests, and mem_ready stretches memory cycles.
interface stack_ctrl_if #(
  parameter int WIDTH = 16
);
  // Control unit request and response
  logic             req_valid;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_data;
  logic             req_ready;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_data;
  logic             resp_error;

  // Stack pointer register side
  logic [WIDTH-1:0] sp_value;
  logic             sp_inc;
  logic             sp_dec;
  logic             sp_write;
  logic [WIDTH-1:0] sp_write_data;

  // Data memory port
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_we;
  logic             mem_re;
  logic             mem_ready;
  logic [WIDTH-1:0] mem_rdata;

  // master: the sequencer itself
  modport master (
    input  req_valid, req_op, req_data, sp_value, mem_ready, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_error,
           sp_inc, sp_dec, sp_write, sp_write_data,
           mem_addr, mem_wdata, mem_we, mem_re
  );

  // slave: control unit, SPR and memory seen together from outside
  modport slave (
    output req_valid, req_op, req_data, sp_value, mem_ready, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_error,
           sp_inc, sp_dec, sp_write, sp_write_data,
           mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/stack_ctrl.sv
// Stack sequencer: turns PUSH/POP/LOAD requests into SPR strobes and data-memory cycles.
// Latency: error T+1, LOAD T+2, PUSH/POP T+3 plus one cycle per memory wait cycle.
// Backpressure: accepts only in IDLE (req_ready), and memory requests are held until mem_ready.
module stack_ctrl #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] STACK_TOP   = 16'hFFFF,
  parameter logic [WIDTH-1:0] STACK_LIMIT = 16'hFF00
) (
  input  logic          clock,
  input  logic          reset,
  stack_ctrl_if.master  bus
);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;

  typedef enum logic [1:0] {IDLE, MEM, UPDATE, RESP} state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;

  logic             req_ready_q;
  logic             resp_valid_q;
  logic             resp_error_q;
  logic [WIDTH-1:0] resp_data_q;
  logic             sp_inc_q;
  logic             sp_dec_q;
  logic             sp_write_q;
  logic [WIDTH-1:0] sp_write_data_q;
  logic [WIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0] mem_wdata_q;
  logic             mem_we_q;
  logic             mem_re_q;

  logic             req_bad;

  // Refuse overflow, underflow and the reserved opcode before any memory or SP side effect
  always_comb begin
    req_bad = 1'b0;
    if (bus.req_op == OP_PUSH && bus.sp_value == STACK_LIMIT) req_bad = 1'b1;
    if (bus.req_op == OP_POP  && bus.sp_value == STACK_TOP)   req_bad = 1'b1;
    if (bus.req_op == 2'b11)                                  req_bad = 1'b1;
  end

  // Sequencer FSM; every output is a register updated here
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      op_q            <= OP_PUSH;
      data_q          <= '0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_error_q    <= 1'b0;
      resp_data_q     <= '0;
      sp_inc_q        <= 1'b0;
      sp_dec_q        <= 1'b0;
      sp_write_q      <= 1'b0;
      sp_write_data_q <= '0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_we_q        <= 1'b0;
      mem_re_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q        <= bus.req_op;
            data_q      <= bus.req_data;
            req_ready_q <= 1'b0;
            if (req_bad) begin
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_data_q  <= bus.sp_value;
              state        <= RESP;
            end else if (bus.req_op == OP_LOAD) begin
              sp_write_q      <= 1'b1;
              sp_write_data_q <= bus.req_data;
              state           <= UPDATE;
            end else if (bus.req_op == OP_PUSH) begin
              // Full-descending: the new word lands just below the current top
              mem_we_q    <= 1'b1;
              mem_addr_q  <= bus.sp_value - WIDTH'(1);
              mem_wdata_q <= bus.req_data;
              state       <= MEM;
            end else begin
              mem_re_q   <= 1'b1;
              mem_addr_q <= bus.sp_value;
              state      <= MEM;
            end
          end
        end
        MEM: begin
          if (bus.mem_ready) begin
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            if (op_q == OP_POP) resp_data_q <= bus.mem_rdata;
            sp_dec_q <= (op_q == OP_PUSH);
            sp_inc_q <= (op_q == OP_POP);
            state    <= UPDATE;
          end
        end
        UPDATE: begin
          sp_inc_q     <= 1'b0;
          sp_dec_q     <= 1'b0;
          sp_write_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_error_q <= 1'b0;
          if (op_q == OP_LOAD) resp_data_q <= data_q;
          state        <= RESP;
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          resp_error_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          req_ready_q <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_error    = resp_error_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.sp_inc        = sp_inc_q;
  assign bus.sp_dec        = sp_dec_q;
  assign bus.sp_write      = sp_write_q;
  assign bus.sp_write_data = sp_write_data_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_re        = mem_re_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with an SPR model and a wait-state memory model.
// Latency: measured per request, from the acceptance edge to the resp_valid cycle.
// Backpressure: requests wait on req_ready, and memory wait states come from mem_wait.
module tb_stack_ctrl;
  localparam int W = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  stack_ctrl_if #(.WIDTH(W)) bus ();

  stack_ctrl #(.WIDTH(W), .STACK_TOP(16'hFFFF), .STACK_LIMIT(16'hFF00)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SPR model driven by the DUT strobes
  logic [W-1:0] spr = '0;
  assign bus.sp_value = spr;
  initial forever begin
    @(posedge clock);
    if (bus.sp_write === 1'b1)    spr <= bus.sp_write_data;
    else if (bus.sp_inc === 1'b1) spr <= spr + 16'd1;
    else if (bus.sp_dec === 1'b1) spr <= spr - 16'd1;
  end

  // Memory model: mem_wait wait cycles before mem_ready, storage keyed by address
  int mem_wait = 0;
  int busy = 0;
  logic [W-1:0] store [logic [W-1:0]];
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (bus.mem_we === 1'b1 || bus.mem_re === 1'b1) begin
        busy++;
        bus.mem_ready = (busy > mem_wait);
        bus.mem_rdata = store.exists(bus.mem_addr) ? store[bus.mem_addr] : 16'hDEAD;
      end else begin
        busy = 0;
        bus.mem_ready = 1'b0;
      end
    end
  end
  initial forever begin
    @(posedge clock);
    if (bus.mem_we === 1'b1 && bus.mem_ready === 1'b1) store[bus.mem_addr] = bus.mem_wdata;
  end

  // Monitor: running totals sampled mid-cycle, never reset
  int c_inc = 0, c_dec = 0, c_wr = 0, c_we = 0, c_re = 0;
  int c_resp = 0, c_err = 0, c_acc = 0, c_inv = 0, c_rdy = 0;
  logic [W-1:0] we_addr = '0, we_data = '0, re_addr = '0;
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      if (bus.sp_inc)   c_inc++;
      if (bus.sp_dec)   c_dec++;
      if (bus.sp_write) c_wr++;
      if (bus.mem_we) begin c_we++; we_addr = bus.mem_addr; we_data = bus.mem_wdata; end
      if (bus.mem_re) begin c_re++; re_addr = bus.mem_addr; end
      if (bus.resp_valid) c_resp++;
      if (bus.resp_valid && bus.resp_error) c_err++;
      if (bus.req_valid && bus.req_ready) c_acc++;
      if (32'(bus.sp_inc) + 32'(bus.sp_dec) + 32'(bus.sp_write) > 1) c_inv++;
      if (bus.mem_we && bus.mem_re) c_inv++;
      if (bus.req_ready && (bus.mem_we || bus.mem_re || bus.sp_inc || bus.sp_dec ||
                            bus.sp_write || bus.resp_valid)) c_rdy++;
    end
  end

  // Issue one request and measure cycles from acceptance to resp_valid
  task automatic do_req(input logic [1:0] op, input logic [W-1:0] d,
                        output int lat, output logic [W-1:0] rd, output logic re);
    int k;
    k = 0;
    @(posedge clock); #1;
    while (!bus.req_ready && k < 50) begin @(posedge clock); #1; k++; end
    if (!bus.req_ready) check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_data  = d;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    @(negedge clock);
    while (!bus.resp_valid && lat < 50) begin @(negedge clock); lat++; end
    if (!bus.resp_valid) check("resp_timeout", 32'(bus.resp_valid), 32'd1);
    rd = bus.resp_data;
    re = bus.resp_error;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [W-1:0] rd;
    logic er;
    int b_inc, b_dec, b_wr, b_we, b_re, b_resp, b_err, b_acc;

    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_data  = '0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_strobes", 32'({bus.sp_inc, bus.sp_dec, bus.sp_write, bus.mem_we,
                              bus.mem_re, bus.resp_valid, bus.resp_error}), 32'd0);
    check("rst_resp_mem_addr", {bus.resp_data, bus.mem_addr}, 32'd0);
    check("rst_wdata", {bus.sp_write_data, bus.mem_wdata}, 32'd0);
    reset = 1'b0;

    // 1: LOAD FFFF then PUSH 1234, zero-wait memory
    b_wr = c_wr;
    do_req(2'b10, 16'hFFFF, lat, rd, er);
    check("s1_load_lat", lat, 32'd2);
    check("s1_load_resp", {15'd0, er, rd}, 32'h0000FFFF);
    check("s1_load_swr", c_wr - b_wr, 32'd1);
    check("s1_load_sp", 32'(spr), 32'hFFFF);

    mem_wait = 0;
    b_we = c_we; b_dec = c_dec;
    do_req(2'b00, 16'h1234, lat, rd, er);
    check("s1_push_lat", lat, 32'd3);
    check("s1_push_err", 32'(er), 32'd0);
    check("s1_push_we_cycles", c_we - b_we, 32'd1);
    check("s1_push_addr_data", {we_addr, we_data}, 32'hFFFE1234);
    check("s1_push_dec", c_dec - b_dec, 32'd1);
    check("s1_push_sp", 32'(spr), 32'hFFFE);

    // 2: POP with two memory wait cycles
    mem_wait = 2;
    b_re = c_re; b_inc = c_inc;
    do_req(2'b01, 16'h0000, lat, rd, er);
    check("s2_pop_lat", lat, 32'd5);
    check("s2_pop_resp", {15'd0, er, rd}, 32'h00001234);
    check("s2_pop_re_cycles", c_re - b_re, 32'd3);
    check("s2_pop_addr", 32'(re_addr), 32'hFFFE);
    check("s2_pop_inc", c_inc - b_inc, 32'd1);
    check("s2_pop_sp", 32'(spr), 32'hFFFF);

    // 3: POP on empty stack
    mem_wait = 0;
    b_re = c_re; b_inc = c_inc; b_dec = c_dec; b_wr = c_wr;
    do_req(2'b01, 16'h0000, lat, rd, er);
    check("s3_underflow_lat", lat, 32'd1);
    check("s3_underflow_resp", {15'd0, er, rd}, 32'h0001FFFF);
    check("s3_no_mem_re", c_re - b_re, 32'd0);
    check("s3_no_sp_strobe", (c_inc - b_inc) + (c_dec - b_dec) + (c_wr - b_wr), 32'd0);

    // 4: LOAD FF00 then PUSH -> overflow
    do_req(2'b10, 16'hFF00, lat, rd, er);
    check("s4_load_resp", {15'd0, er, rd}, 32'h0000FF00);
    b_we = c_we; b_dec = c_dec;
    do_req(2'b00, 16'hAAAA, lat, rd, er);
    check("s4_overflow_lat", lat, 32'd1);
    check("s4_overflow_resp", {15'd0, er, rd}, 32'h0001FF00);
    check("s4_no_we_dec", (c_we - b_we) + (c_dec - b_dec), 32'd0);
    check("s4_sp", 32'(spr), 32'hFF00);

    // 5: reserved op, single then back-to-back with req_valid held
    do_req(2'b11, 16'h5A5A, lat, rd, er);
    check("s5_rsv_lat", lat, 32'd1);
    check("s5_rsv_resp", {15'd0, er, rd}, 32'h0001FF00);
    @(posedge clock); #1;
    b_acc = c_acc; b_resp = c_resp; b_err = c_err;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b11;
    repeat (12) @(negedge clock);
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    check("s5_b2b_accepts", c_acc - b_acc, 32'd6);
    check("s5_b2b_resps", c_resp - b_resp, 32'd6);
    check("s5_b2b_errs", c_err - b_err, 32'd6);

    // 6: reset during a stalled PUSH
    do_req(2'b10, 16'hFFFF, lat, rd, er);
    mem_wait = 1000;
    b_dec = c_dec; b_resp = c_resp;
    @(posedge clock); #1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_data  = 16'h5555;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("s6_stalled_we", 32'(bus.mem_we), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("s6_rst_we", 32'(bus.mem_we), 32'd0);
    check("s6_rst_ready", 32'(bus.req_ready), 32'd1);
    repeat (8) @(posedge clock);
    #1;
    check("s6_no_dec_resp", (c_dec - b_dec) + (c_resp - b_resp), 32'd0);
    check("s6_sp", 32'(spr), 32'hFFFF);
    mem_wait = 0;
    do_req(2'b10, 16'hFFF0, lat, rd, er);
    check("s6_after_rst_load", {lat[7:0], 7'd0, er, rd}, 32'h0200FFF0);

    // Run-wide invariants
    check("inv_exclusive", c_inv, 32'd0);
    check("inv_ready_busy", c_rdy, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
